// File: rtl/intc_pkg.sv
// Shared definitions for the memory-mapped interrupt controller:
// register offsets, FSM state encoding, the "nothing to claim" value and
// the id-width helper.
package intc_pkg;

  // Byte offsets of the four registers inside the 16-byte window.
  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_MASK    = 4'h4;
  localparam logic [3:0] OFF_CLAIM   = 4'h8;
  localparam logic [3:0] OFF_EOI     = 4'hc;

  // Value returned by a CLAIM read that cannot hand out an interrupt.
  localparam logic [31:0] NO_CLAIM = 32'hffff_ffff;

  typedef enum logic [1:0] {
    INTC_IDLE       = 2'd0,
    INTC_ASSERT     = 2'd1,
    INTC_IN_SERVICE = 2'd2
  } intc_state_e;

  // Width of a source id. A single-source controller still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_pick.sv
// Combinational priority picker: returns the first set request found when
// scanning upward from 'start', wrapping at NUM_SRC. Tying start to 0 gives
// plain fixed (lowest-index-first) priority.
module intc_prio_pick
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IW      = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      start,
  output logic               valid,
  output logic [IW-1:0]      id
);

  int idx;

  // Scan all sources once, starting at 'start', and keep the first hit.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned and no latch is
  // inferred.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!valid && |(req & (NUM_SRC'(1) << idx))) begin
        valid = 1'b1;
        id    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller. Latches rising edges of up to 16
// device lines, masks them, and sequences claim / end-of-interrupt towards
// the single cp0 interrupt input.
// Optional build macro: INTC_ROUND_ROBIN_EN selects rotating priority
// (search starts after the last claimed id); without it priority is fixed,
// lowest index first.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'hffff_0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  input  logic               MemRead,
  input  logic               MemWrite,
  output logic [31:0]        rd_data,
  output logic               IntcAddress,
  output logic               IntcIrq
);

  localparam int IW = id_width(NUM_SRC);

  logic [NUM_SRC-1:0] pending, mask, prev_irq;
  logic [NUM_SRC-1:0] src_edge, masked, w1c, claim_clear;
  logic [IW-1:0]      active_id, start_idx, win_id;
  logic               win_valid;
  logic               rd_hit, wr_hit, claim_ok, eoi_wr;
  logic [1:0]         reg_sel;
  intc_state_e        state, state_next;

  // Address decode: one 16-byte window, word-granular register select.
  assign IntcAddress = (address[31:4] == BASE_ADDR[31:4]);
  assign reg_sel     = address[3:2];
  assign rd_hit      = MemRead  && IntcAddress;
  assign wr_hit      = MemWrite && IntcAddress;

  assign src_edge = src_irq & ~prev_irq;
  assign masked   = pending & mask;

  intc_prio_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
    .req   (masked),
    .start (start_idx),
    .valid (win_valid),
    .id    (win_id)
  );

  // A claim only succeeds while the request is being presented and there is
  // still something masked-pending to hand out.
  assign claim_ok    = rd_hit && (reg_sel == OFF_CLAIM[3:2]) &&
                       (state == INTC_ASSERT) && win_valid;
  assign claim_clear = claim_ok ? (NUM_SRC'(1) << win_id) : '0;
  assign w1c         = (wr_hit && (reg_sel == OFF_PENDING[3:2])) ?
                       wr_data[NUM_SRC-1:0] : '0;
  assign eoi_wr      = wr_hit && (reg_sel == OFF_EOI[3:2]);

`ifdef INTC_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Next search start: one past the most recently claimed id, wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (claim_ok) begin
      rr_ptr <= (win_id == IW'(NUM_SRC - 1)) ? '0 : win_id + 1'b1;
    end
  end

  assign start_idx = rr_ptr;
`else
  assign start_idx = '0;
`endif

  // Register file and edge detector. New edges win over W1C and claim
  // clears of the same bit, so no event is ever lost.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      mask      <= '0;
      prev_irq  <= '0;
      active_id <= '0;
      state     <= INTC_IDLE;
    end else begin
      prev_irq <= src_irq;
      pending  <= (pending & ~w1c & ~claim_clear) | src_edge;
      if (wr_hit && (reg_sel == OFF_MASK[3:2])) mask <= wr_data[NUM_SRC-1:0];
      if (claim_ok) active_id <= win_id;
      state <= state_next;
    end
  end

  // Claim sequencing: present, hand out on CLAIM, wait for EOI.
  always_comb begin
    state_next = state;
    unique case (state)
      INTC_IDLE:       if (|masked) state_next = INTC_ASSERT;
      INTC_ASSERT:     if (claim_ok)     state_next = INTC_IN_SERVICE;
                       else if (!(|masked)) state_next = INTC_IDLE;
      INTC_IN_SERVICE: if (eoi_wr)  state_next = INTC_IDLE;
      default:         state_next = INTC_IDLE;
    endcase
  end

  // Registered-state decode keeps src_irq off any combinational path to cp0.
  assign IntcIrq = (state == INTC_ASSERT);

  // Load data mux; reflects register contents before any same-cycle store.
  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      unique case (reg_sel)
        OFF_PENDING[3:2]: rd_data = 32'(pending);
        OFF_MASK[3:2]:    rd_data = 32'(mask);
        OFF_CLAIM[3:2]:   rd_data = claim_ok ? 32'(win_id) : NO_CLAIM;
        default:          rd_data = '0;
      endcase
    end
  end

  // Byte-lane bits, unused data bits and the service id are not consumed.
  logic unused;
  assign unused = ^{address[1:0], wr_data[31:NUM_SRC], active_id};

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller (4 sources, default window).
// Honours INTC_ROUND_ROBIN_EN when the design is built with it.
module tb_interrupt_controller;
  import intc_pkg::*;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'hffff_0010;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src_irq;
  logic [31:0]   address, wr_data, rd_data;
  logic          MemRead, MemWrite, IntcAddress, IntcIrq;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [N-1:0] m_pending, m_mask, m_prev;
  bit           m_irq, m_serv;
  int           m_ptr;

  interrupt_controller #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_irq     (src_irq),
    .address     (address),
    .wr_data     (wr_data),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .rd_data     (rd_data),
    .IntcAddress (IntcAddress),
    .IntcIrq     (IntcIrq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one full clock; inputs are driven and outputs sampled at negedge.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
    address = BASE + 32'(off);
    MemRead = 1'b1;
    #1;
    d = rd_data;
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
    address  = BASE + 32'(off);
    wr_data  = d;
    MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] s);
    src_irq = s;
    cycle();
    src_irq = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    src_irq  = '0;
    address  = '0;
    wr_data  = '0;
    #2;
    check("reset_irq", 32'(IntcIrq), 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    m_pending = '0; m_mask = '0; m_prev = '0;
    m_irq = 1'b0; m_serv = 1'b0; m_ptr = 0;
  endtask

  // Rotating search from 'start'; -1 when nothing requested.
  function automatic int pick(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] src;
    logic [31:0]  exp_pend;
    logic [31:0]  exp_claim;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] d;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    src_irq = '0; address = '0; wr_data = '0;

    vecs[0] = '{4'hf, 4'h1, 32'h1, 32'h0};
    vecs[1] = '{4'hf, 4'h6, 32'h6, 32'h1};
    vecs[2] = '{4'hc, 4'h6, 32'h6, 32'h2};
    vecs[3] = '{4'h0, 4'h9, 32'h9, NO_CLAIM};
    vecs[4] = '{4'h8, 4'hf, 32'hf, 32'h3};
    vecs[5] = '{4'h2, 4'h5, 32'h5, NO_CLAIM};

    // --- Reset state ---
    do_reset();
    bus_read(OFF_PENDING, d); check("reset_pending", d, 32'h0);
    bus_read(OFF_MASK, d);    check("reset_mask", d, 32'h0);
    check("intc_address_in", 32'(IntcAddress), 32'd1);

    // --- Table-driven vectors ---
    foreach (vecs[i]) begin
      do_reset();
      bus_write(OFF_MASK, 32'(vecs[i].mask));
      pulse(vecs[i].src);
      cycle();
      bus_read(OFF_PENDING, d);
      check($sformatf("vec%0d_pending", i), d, vecs[i].exp_pend);
      check($sformatf("vec%0d_irq", i), 32'(IntcIrq), 32'(vecs[i].exp_claim != NO_CLAIM));
      bus_read(OFF_CLAIM, d);
      check($sformatf("vec%0d_claim", i), d, vecs[i].exp_claim);
      bus_read(OFF_PENDING, d);
      check($sformatf("vec%0d_pending_after", i), d,
            (vecs[i].exp_claim == NO_CLAIM) ? vecs[i].exp_pend
                                            : vecs[i].exp_pend & ~(32'd1 << vecs[i].exp_claim));
    end

    // --- Masked-off pending, then unmask ---
    do_reset();
    pulse(4'h4);
    cycle(); cycle();
    check("masked_irq_low", 32'(IntcIrq), 32'd0);
    bus_read(OFF_PENDING, d); check("masked_pending", d, 32'h4);
    bus_write(OFF_MASK, 32'h4);
    cycle();
    check("unmask_irq_high", 32'(IntcIrq), 32'd1);

    // --- Simultaneous edges, claim, EOI, second claim ---
    do_reset();
    bus_write(OFF_MASK, 32'hf);
    pulse(4'ha);
    cycle();
    bus_read(OFF_CLAIM, d);   check("claim_first", d, 32'h1);
    bus_read(OFF_PENDING, d); check("pending_after_claim", d, 32'h8);
    check("irq_in_service", 32'(IntcIrq), 32'd0);
    bus_read(OFF_CLAIM, d);   check("claim_in_service", d, NO_CLAIM);
    bus_write(OFF_EOI, 32'h1234);
    check("irq_after_eoi", 32'(IntcIrq), 32'd0);
    cycle();
    check("irq_reassert", 32'(IntcIrq), 32'd1);
    bus_read(OFF_CLAIM, d);   check("claim_second", d, 32'h3);
    bus_write(OFF_EOI, 32'h0);
    bus_read(OFF_CLAIM, d);   check("claim_empty", d, NO_CLAIM);

    // --- W1C coincident with a new edge: set wins ---
    src_irq = 4'h1;
    bus_write(OFF_PENDING, 32'h1);
    src_irq = '0;
    bus_read(OFF_PENDING, d); check("w1c_vs_edge", d, 32'h1);
    bus_write(OFF_PENDING, 32'h1);
    cycle();
    bus_read(OFF_PENDING, d); check("w1c_clears", d, 32'h0);
    check("irq_after_w1c", 32'(IntcIrq), 32'd0);

    // --- Level held high latches exactly one edge ---
    do_reset();
    src_irq = 4'h1;
    repeat (10) cycle();
    bus_read(OFF_PENDING, d); check("held_pending", d, 32'h1);
    bus_write(OFF_PENDING, 32'h1);
    cycle();
    bus_read(OFF_PENDING, d); check("held_single_edge", d, 32'h0);
    src_irq = '0;

    // --- Reset in the middle of IN_SERVICE ---
    do_reset();
    bus_write(OFF_MASK, 32'hf);
    pulse(4'h4);
    cycle();
    bus_read(OFF_CLAIM, d); check("claim_before_reset", d, 32'h2);
    pulse(4'h1);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_irq", 32'(IntcIrq), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus_read(OFF_PENDING, d); check("post_reset_pending", d, 32'h0);
    bus_read(OFF_MASK, d);    check("post_reset_mask", d, 32'h0);
    bus_read(OFF_CLAIM, d);   check("post_reset_claim", d, NO_CLAIM);

    // --- Claim/EOI sweep over all sources, then refire 0 and 1 ---
    do_reset();
    bus_write(OFF_MASK, 32'hf);
    pulse(4'hf);
    cycle();
    for (int i = 0; i < 4; i++) begin
      bus_read(OFF_CLAIM, d); check($sformatf("sweep_claim%0d", i), d, 32'(i));
      bus_write(OFF_EOI, 32'h0);
      cycle();
    end
    pulse(4'h3);
    cycle();
    bus_read(OFF_CLAIM, d); check("refire_claim0", d, 32'h0);
    bus_write(OFF_EOI, 32'h0);
    cycle();
    bus_read(OFF_CLAIM, d); check("refire_claim1", d, 32'h1);
    bus_write(OFF_EOI, 32'h0);

    // --- Randomized traffic against the behavioural model ---
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] s, masked, w1c, edges, clr;
      logic [1:0]   off;
      logic         rd, wr, inwin, claim, eoi;
      logic [31:0]  wd, exp_rd;
      int           cid;

      s     = ($urandom_range(0, 3) == 0) ? N'($urandom) : src_irq;
      rd    = ($urandom_range(0, 2) == 0);
      wr    = ($urandom_range(0, 3) == 0);
      off   = 2'($urandom);
      inwin = ($urandom_range(0, 7) != 0);
      wd    = $urandom;

      src_irq  = s;
      MemRead  = rd;
      MemWrite = wr;
      wr_data  = wd;
      address  = inwin ? BASE + {28'd0, off, 2'b00}
                       : 32'h0000_1000 + {28'd0, off, 2'b00};
      #1;
      check("rand_addr_decode", 32'(IntcAddress), 32'(inwin));
      check("rand_irq", 32'(IntcIrq), 32'(m_irq));

      masked = m_pending & m_mask;
      claim  = 1'b0;
      cid    = pick(masked, m_ptr);
      if (rd && inwin && off != 2'd3) begin
        case (off)
          2'd0: exp_rd = 32'(m_pending);
          2'd1: exp_rd = 32'(m_mask);
          default: begin
            if (m_irq && cid >= 0) begin
              exp_rd = 32'(cid);
              claim  = 1'b1;
            end else begin
              exp_rd = NO_CLAIM;
            end
          end
        endcase
        check("rand_rd_data", rd_data, exp_rd);
      end

      w1c   = (wr && inwin && off == 2'd0) ? wd[N-1:0] : '0;
      eoi   = wr && inwin && off == 2'd3;
      edges = s & ~m_prev;
      clr   = claim ? N'(1 << cid) : '0;
      m_prev    = s;
      m_pending = (m_pending & ~w1c & ~clr) | edges;
      if (wr && inwin && off == 2'd1) m_mask = wd[N-1:0];
      if (m_serv) begin
        m_irq  = 1'b0;
        m_serv = !eoi;
      end else if (claim) begin
        m_irq  = 1'b0;
        m_serv = 1'b1;
      end else begin
        m_irq = |masked;
      end
`ifdef INTC_ROUND_ROBIN_EN
      if (claim) m_ptr = (cid + 1) % N;
`endif
      @(negedge clk);
    end
    MemRead = 1'b0; MemWrite = 1'b0; src_irq = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
